// File: rtl/sad_pkg.sv
// Shared definitions for the per-partition minimum-SAD trackers:
// lane counts, SAD widths, default search range and the tracker state type.
package sad_pkg;

    // Lane count / SAD width pairs, one pair per partition size
    localparam int NUM_BLK_4X8  = 32;
    localparam int SAD_W_4X8    = 13;
    localparam int NUM_BLK_8X8  = 16;
    localparam int SAD_W_8X8    = 14;
    localparam int NUM_BLK_8X16 = 8;
    localparam int SAD_W_8X16   = 15;
    localparam int NUM_BLK_16X16 = 4;
    localparam int SAD_W_16X16  = 16;

    localparam int DEF_SR_W = 64;
    localparam int DEF_SR_H = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // SAD width that goes with a given lane count; 0 for an unknown partition
    function automatic int sad_w_for_lanes(input int lanes);
        case (lanes)
            NUM_BLK_4X8:   return SAD_W_4X8;
            NUM_BLK_8X8:   return SAD_W_8X8;
            NUM_BLK_8X16:  return SAD_W_8X16;
            NUM_BLK_16X16: return SAD_W_16X16;
            default:       return 0;
        endcase
    endfunction

endpackage

// File: rtl/sad_min_lane.sv
// One partition lane: running minimum SAD and the raw candidate index that
// produced it; the MV is that index re-centred by flipping its MSB.
module sad_min_lane #(
    parameter int SAD_W = 13,
    parameter int XW    = 6,
    parameter int YW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             first,
    input  logic             en,
    input  logic [SAD_W-1:0] sad,
    input  logic [XW-1:0]    cx,
    input  logic [YW-1:0]    cy,
    output logic [SAD_W-1:0] min_sad,
    output logic [XW-1:0]    best_mvx,
    output logic [YW-1:0]    best_mvy
);

    localparam logic [XW-1:0] X_HALF = XW'(1) << (XW - 1);
    localparam logic [YW-1:0] Y_HALF = YW'(1) << (YW - 1);

    logic [SAD_W-1:0] min_q;
    logic [XW-1:0]    idx_x;
    logic [YW-1:0]    idx_y;
    logic             update;

    // Strict less-than keeps the earliest candidate on ties
    assign update = en && (first || (sad < min_q));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= '1;
            idx_x <= '0;
            idx_y <= '0;
        end else if (clr) begin
            min_q <= '1;
            idx_x <= '0;
            idx_y <= '0;
        end else if (update) begin
            min_q <= sad;
            idx_x <= cx;
            idx_y <= cy;
        end
    end

    assign min_sad  = min_q;
    assign best_mvx = idx_x ^ X_HALF;
    assign best_mvy = idx_y ^ Y_HALF;

endmodule

// File: rtl/sad_min_tracker.sv
// Per-partition minimum-SAD tracker: raster-scans an SR_W x SR_H window, one
// beat of NUM_BLK lane SADs per candidate, and keeps min SAD + MV per lane.
module sad_min_tracker
    import sad_pkg::*;
#(
    parameter int NUM_BLK = NUM_BLK_4X8,
    parameter int SAD_W   = SAD_W_4X8,
    parameter int SR_W    = DEF_SR_W,
    parameter int SR_H    = DEF_SR_H
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             sad_valid,
    input  logic [NUM_BLK*SAD_W-1:0]         sad_in,
    output logic                             sad_ready,
    output logic [NUM_BLK*SAD_W-1:0]         min_sad,
    output logic [NUM_BLK*$clog2(SR_W)-1:0]  best_mvx,
    output logic [NUM_BLK*$clog2(SR_H)-1:0]  best_mvy,
    output logic                             busy,
    output logic                             done,
    output logic                             result_valid
);

    localparam int XW = $clog2(SR_W);
    localparam int YW = $clog2(SR_H);
    localparam logic [XW-1:0] X_LAST = XW'(SR_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SR_H - 1);

    state_t         state, state_n;
    logic [XW-1:0]  cx;
    logic [YW-1:0]  cy;
    logic           done_q;
    logic           accept;
    logic           first_beat;
    logic           last_beat;

    // A beat arriving together with start belongs to the aborted search
    assign accept     = sad_valid && (state == SEARCH) && !start;
    assign first_beat = (cx == '0) && (cy == '0);
    assign last_beat  = accept && (cx == X_LAST) && (cy == Y_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: state_n gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = SEARCH;
            SEARCH: begin
                if (start)          state_n = SEARCH;
                else if (last_beat) state_n = DONE;
            end
            DONE:    if (start) state_n = SEARCH;
            default: state_n = IDLE;
        endcase
    end

    // Raster candidate counter; stalls while sad_valid is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx <= '0;
            cy <= '0;
        end else if (start) begin
            cx <= '0;
            cy <= '0;
        end else if (accept) begin
            if (cx == X_LAST) begin
                cx <= '0;
                cy <= cy + YW'(1);
            end else begin
                cx <= cx + XW'(1);
            end
        end
    end

    // done rises on the same edge that makes the last beat's result visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= last_beat;
        end
    end

    for (genvar i = 0; i < NUM_BLK; i++) begin : g_lane
        sad_min_lane #(
            .SAD_W (SAD_W),
            .XW    (XW),
            .YW    (YW)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (start),
            .first    (first_beat),
            .en       (accept),
            .sad      (sad_in[i*SAD_W +: SAD_W]),
            .cx       (cx),
            .cy       (cy),
            .min_sad  (min_sad[i*SAD_W +: SAD_W]),
            .best_mvx (best_mvx[i*XW +: XW]),
            .best_mvy (best_mvy[i*YW +: YW])
        );
    end

    assign sad_ready    = (state == SEARCH);
    assign busy         = (state == SEARCH);
    assign result_valid = (state == DONE);
    assign done         = done_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Scoreboard bench for sad_min_tracker with 2 lanes, 13-bit SADs, 4x4 window.
module tb_sad_min_tracker;

    localparam int NB = 2;
    localparam int SW = 13;
    localparam int RW = 4;
    localparam int RH = 4;

    typedef struct packed {
        logic [NB*SW-1:0] min;
        logic [2*NB-1:0]  mvx;
        logic [2*NB-1:0]  mvy;
    } exp_t;

    localparam logic [NB*SW-1:0] MIN_INIT = {NB*SW{1'b1}};
    localparam logic [2*NB-1:0]  MV_RAW0  = 4'b1010;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 sad_valid = 1'b0;
    logic [NB*SW-1:0]     sad_in = '0;
    logic                 sad_ready;
    logic [NB*SW-1:0]     min_sad;
    logic [2*NB-1:0]      best_mvx;
    logic [2*NB-1:0]      best_mvy;
    logic                 busy;
    logic                 done;
    logic                 result_valid;

    int n_vec = 0;
    int n_err = 0;
    exp_t exp_q[$];

    sad_min_tracker #(
        .NUM_BLK (NB),
        .SAD_W   (SW),
        .SR_W    (RW),
        .SR_H    (RH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .sad_valid    (sad_valid),
        .sad_in       (sad_in),
        .sad_ready    (sad_ready),
        .min_sad      (min_sad),
        .best_mvx     (best_mvx),
        .best_mvy     (best_mvy),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NB*SW-1:0] pack(input int l0, input int l1);
        return {SW'(l1), SW'(l0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input int l0, input int l1);
        sad_valid = 1'b1;
        sad_in    = pack(l0, l1);
        tick();
        sad_valid = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest expected result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_min_sad", 32'(min_sad), 32'(e.min));
                    check("sb_best_mvx", 32'(best_mvx), 32'(e.mvx));
                    check("sb_best_mvy", 32'(best_mvy), 32'(e.mvy));
                    check("sb_result_valid", 32'(result_valid), 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and idle
        repeat (3) tick();
        @(negedge clk);
        check("in_reset_min", 32'(min_sad), 32'(MIN_INIT));
        rst_n = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("idle_min", 32'(min_sad), 32'(MIN_INIT));
        check("idle_mvx", 32'(best_mvx), 32'(MV_RAW0));
        check("idle_mvy", 32'(best_mvy), 32'(MV_RAW0));
        check("idle_done", 32'(done), 32'd0);
        check("idle_ready", 32'(sad_ready), 32'd0);
        check("idle_rv", 32'(result_valid), 32'd0);

        // Normal search: lane0 min 7 at (1,1) -> mv (-1,-1); lane1 tie keeps (0,0)
        exp_q.push_back('{min: pack(7, 50), mvx: 4'b1011, mvy: 4'b1011});
        pulse_start();
        @(negedge clk);
        check("search_ready", 32'(sad_ready), 32'd1);
        check("search_busy", 32'(busy), 32'd1);
        for (int k = 0; k < RW * RH; k++) begin
            beat((k == 5) ? 7 : 100, 50);
            if (k == 0) begin
                @(negedge clk);
                check("latency1_min", 32'(min_sad), 32'(pack(100, 50)));
            end
        end
        @(negedge clk);
        check("done_timing", 32'(done), 32'd1);
        tick();
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("rv_held", 32'(result_valid), 32'd1);

        // Start from DONE reinitialises on the same edge
        pulse_start();
        @(negedge clk);
        check("restart_rv_drop", 32'(result_valid), 32'd0);
        check("restart_ready", 32'(sad_ready), 32'd1);
        check("restart_min_init", 32'(min_sad), 32'(MIN_INIT));

        // All-ones SADs: first beat loads, later ties never replace it
        exp_q.push_back('{min: pack(8191, 8191), mvx: MV_RAW0, mvy: MV_RAW0});
        for (int k = 0; k < RW * RH; k++) beat(8191, 8191);
        tick();

        // Gapped beats, garbage SADs during gaps must be ignored
        exp_q.push_back('{min: pack(7, 50), mvx: 4'b1011, mvy: 4'b1011});
        pulse_start();
        for (int k = 0; k < RW * RH; k++) begin
            beat((k == 5) ? 7 : 100, 50);
            sad_in = pack(0, 0);
            if (k != RW * RH - 1) begin
                @(negedge clk);
                check("gap_no_done", 32'(done), 32'd0);
                tick();
            end
        end
        @(negedge clk);
        check("gap_done_timing", 32'(done), 32'd1);
        tick();

        // Restart mid-search: beat carried with start is dropped
        pulse_start();
        for (int k = 0; k < 9; k++) beat(1, 1);
        start     = 1'b1;
        sad_valid = 1'b1;
        sad_in    = pack(0, 0);
        tick();
        start     = 1'b0;
        sad_valid = 1'b0;
        @(negedge clk);
        check("abort_min_init", 32'(min_sad), 32'(MIN_INIT));
        check("abort_busy", 32'(busy), 32'd1);
        // lane0 min 150 at (3,3) -> mv (1,1); lane1 min 20 at (2,2) -> mv (0,0)
        exp_q.push_back('{min: pack(150, 20), mvx: 4'b0001, mvy: 4'b0001});
        for (int k = 0; k < RW * RH; k++) beat(300 - 10 * k, (k == 10) ? 20 : 60);
        tick();

        // Asynchronous reset in the middle of a search
        pulse_start();
        for (int k = 0; k < 6; k++) beat(5, 5);
        sad_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_min", 32'(min_sad), 32'(MIN_INIT));
        check("async_rst_mvx", 32'(best_mvx), 32'(MV_RAW0));
        check("async_rst_mvy", 32'(best_mvy), 32'(MV_RAW0));
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_ready", 32'(sad_ready), 32'd0);
        check("async_rst_rv", 32'(result_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) beat(3, 3);
        @(negedge clk);
        check("post_rst_ready", 32'(sad_ready), 32'd0);
        check("post_rst_min", 32'(min_sad), 32'(MIN_INIT));
        check("post_rst_rv", 32'(result_valid), 32'd0);

        // Every expected result must have been consumed
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sad_min_tracker.md
# sad_min_tracker

Parametrised per-partition minimum-SAD tracker with motion-vector argmin for integer motion estimation. It accepts one beat of NUM_BLK lane SADs per search candidate and scans a raster SR_W×SR_H search window. Per lane it keeps the running minimum SAD and the motion vector that produced it, then signals completion. It sits between the SAD adder tree and MV decision logic. One instance is used per partition size: 4x8/8x4 use 32×13b, 8x8 uses 16×14b, 8x16/16x8 use 8×15b, and 16x16 uses 4×16b.

## Interface
- NUM_BLK, 32, number of independent partition lanes
- SAD_W, 13, SAD width per lane (unsigned)
- SR_W, 64, search window width in candidates (power of 2, ≥2)
- SR_H, 64, search window height in candidates (power of 2, ≥2)
- XW / YW, derived: $clog2(SR_W), $clog2(SR_H)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  begin new search; aborts and restarts if a search is in progress
- sad_valid  in  1  sad_in carries the SADs of the current candidate
- sad_in  in  NUM_BLK*SAD_W  lane i at [i*SAD_W +: SAD_W]
- sad_ready  out  1  high in SEARCH state; sad_valid ignored otherwise
- min_sad  out  NUM_BLK*SAD_W  running or final minimum per lane
- best_mvx  out  NUM_BLK*XW  signed two's complement, = cx − SR_W/2
- best_mvy  out  NUM_BLK*YW  signed two's complement, = cy − SR_H/2
- busy  out  1  high in SEARCH
- done  out  1  one-cycle pulse on entering DONE
- result_valid  out  1  high in DONE, until next start

## Operation
- States: IDLE → SEARCH on start; SEARCH → DONE on accepted last beat; DONE → SEARCH on start; SEARCH → SEARCH (restart) on start.
- Entering SEARCH:
  - Candidate counter (cx, cy) is cleared to (0, 0).
  - min_sad is set to all-ones and the MVs are cleared.
- Accepted beat = sad_valid && state==SEARCH && !start. A sad_valid coinciding with start is dropped.
- Per accepted beat, for each lane i:
  - The first beat of a search (cx=cy=0) loads unconditionally.
  - Later beats update when sad_in[i] < min_sad[i] (strict). Ties keep the earlier candidate.
  - On update, the lane captures sad_in[i] and (cx, cy).
- Comparison is unsigned over the full SAD_W bits. An all-ones input is legal and is loaded only on the first beat.
- Counter advance per accepted beat:
  - cx increments.
  - At cx==SR_W−1, cx wraps to 0 and cy increments.
  - The beat at (SR_W−1, SR_H−1) is the last beat and moves the FSM to DONE.
- MV output is combinational from the stored raw index, with the MSB inverted (equal to idx − half-range).
- Reset (any time, including mid-search):
  - state=IDLE
  - min_sad all-ones, best_mvx=best_mvy = −SR_W/2 / −SR_H/2 (raw 0)
  - done=0, busy=0, result_valid=0, sad_ready=0
  - counter 0

## Timing
- Latency 1: min_sad and MVs reflect a beat in the cycle after it is accepted.
- done pulses, and result_valid rises, in the same cycle that the last beat's result becomes visible.
- Back-to-back beats are allowed every cycle. No backpressure beyond sad_ready=0 outside SEARCH.
- A start in DONE:
  - result_valid drops the next cycle.
  - sad_ready is high the next cycle.
  - Mins reinitialise on the same edge.
- Gaps in sad_valid stall the counter. The counter does not time out.

## Structure
- Shared package sad_pkg holds:
  - Per-partition SAD widths (13/14/15/16) and lane counts (32/16/8/4).
  - Default SR_W/SR_H.
  - The state enum {IDLE, SEARCH, DONE}.
- Sub-module sad_min_lane holds one lane's compare, min register and MV register. Inputs are first, en, sad, cx, cy. The top generates NUM_BLK instances plus the shared FSM and counter.

## Test plan
Bench parameters: NUM_BLK=2, SAD_W=13, SR_W=SR_H=4.
- Reset, then idle: min_sad=0x1FFF per lane, mvx=mvy=−2, done=0, sad_ready=0.
- Normal search:
  - Stimulus: start, then 16 consecutive beats; lane0 SAD = 100 except candidate 5 = 7; lane1 SAD constant 50.
  - Response: done pulses 1 cycle after beat 16. Lane0 min=7, mv=(−1,−1). Lane1 min=50, mv=(−2,−2) (tie keeps first).
- First beat all-ones: all SADs 0x1FFF → min 0x1FFF, mv=(−2,−2), result_valid=1.
- Gapped sad_valid: toggle every other cycle → identical result to back-to-back; done 16 accepted beats later.
- Restart:
  - Stimulus: start asserted at beat 9 together with sad_valid.
  - Response: that beat is dropped, counter=0, mins reset. A following full 16-beat search gives a result depending only on the new beats.
- Mid-search reset: assert rst_n=0 at beat 6 → all outputs at reset values immediately (async); later beats ignored until start.
